// File: rtl/_load_scheduler8_pkg.sv
// Shared constants and state encoding for the 8-way load scheduler.
package sched_pkg;
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } sched_state_e;
endpackage

// File: rtl/_load_scheduler8_demux8way.sv
// One-bit 1-to-8 demultiplexer: routes din to output sel, all others zero.
module _demux8way
    import sched_pkg::*;
(
    input  logic             din,
    input  logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] dout
);
    always_comb begin
        dout      = '0;
        dout[sel] = din;
    end
endmodule

// File: rtl/_load_scheduler8_rr_pick8.sv
// Rotating priority encoder: first set request bit scanning ptr, ptr+1, ... mod 8.
module _rr_pick8
    import sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    logic [SEL_W-1:0] cand;

    // Scan from farthest to nearest so the nearest hit is the last assignment.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/_load_scheduler8.sv
// Round-robin write-side scheduler for an 8-entry register bank with per-owner hold limit.
// Optional macro SCHED_PRIO0_EN makes requester 0 an urgent, preempting requester.
//
// state | meaning
// IDLE  | no grant outstanding, next winner scanned from ptr
// OWN   | grant held by requester sel_q, hold_cnt_q counts consecutive cycles
module _load_scheduler8
    import sched_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [SEL_W-1:0]        sel,
    output logic                    load,
    output logic [N_REQ-1:0]        load_vec,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    busy
);
    localparam int HC_W = $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

    sched_state_e     state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             load_q, load_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic [SEL_W-1:0] g_next;
    logic [SEL_W-1:0] g_succ;

    // While owning, every re-arbitration starts just past the current owner.
    assign g_succ   = sel_q + SEL_W'(1);
    assign pick_ptr = (state_q == OWN) ? g_succ : ptr_q;

    _rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        g_next     = sel_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = OWN;
                    g_next     = pick_idx;
                    hold_cnt_d = HC_W'(1);
                end
            end
            OWN: begin
                if (!req[sel_q]) begin
                    ptr_d = g_succ;
                    if (pick_found) begin
                        g_next     = pick_idx;
                        hold_cnt_d = HC_W'(1);
                    end else begin
                        state_d    = IDLE;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q < HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end else if (pick_idx != sel_q) begin
                    ptr_d      = g_succ;
                    g_next     = pick_idx;
                    hold_cnt_d = HC_W'(1);
                end else begin
                    hold_cnt_d = HC_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase

`ifdef SCHED_PRIO0_EN
        if (state_q == OWN && req[0]) begin
            state_d    = OWN;
            ptr_d      = ptr_q;
            g_next     = '0;
            hold_cnt_d = (sel_q == '0) ? hold_cnt_q : HC_W'(1);
        end
`endif

        load_d    = (state_d == OWN);
        grant_d   = load_d ? (N_REQ'(1) << g_next) : '0;
        sel_d     = load_d ? g_next : sel_q;
        wr_data_d = load_d ? req_data[g_next*DATA_W +: DATA_W] : wr_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            sel_q      <= '0;
            load_q     <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            load_q     <= load_d;
            wr_data_q  <= wr_data_d;
        end
    end

    _demux8way u_demux (
        .din  (load_q),
        .sel  (sel_q),
        .dout (load_vec)
    );

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign load    = load_q;
    assign wr_data = wr_data_q;
    assign busy    = |req;
endmodule

// File: tb/tb__load_scheduler8.sv
// Directed-vector bench for _load_scheduler8 (DATA_W=16, MAX_HOLD=4).
module tb__load_scheduler8;
    localparam int DW = 16;

    logic           clk;
    logic           rst_n;
    logic [7:0]     req;
    logic [8*DW-1:0] req_data;
    logic [7:0]     grant;
    logic [2:0]     sel;
    logic           load;
    logic [7:0]     load_vec;
    logic [DW-1:0]  wr_data;
    logic           busy;

    int n_cmp = 0;
    int n_mis = 0;

    _load_scheduler8 #(.DATA_W(DW), .MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .sel      (sel),
        .load     (load),
        .load_vec (load_vec),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] s, input logic l);
        logic [7:0] lv;
        lv = l ? (8'h01 << s) : 8'h00;
        check_eq({tag, ".grant"}, 32'(grant), 32'(g));
        check_eq({tag, ".sel"}, 32'(sel), 32'(s));
        check_eq({tag, ".load"}, 32'(load), 32'(l));
        check_eq({tag, ".load_vec"}, 32'(load_vec), 32'(lv));
    endtask

    initial begin
        logic [7:0] eg;
        logic [2:0] es;
        logic       prio;
`ifdef SCHED_PRIO0_EN
        prio = 1'b1;
`else
        prio = 1'b0;
`endif
        rst_n = 1'b0;
        req   = 8'h00;
        for (int i = 0; i < 8; i++) req_data[i*DW +: DW] = 16'(16'h1111 * i);

        #12;
        chk_out("reset", 8'h00, 3'd0, 1'b0);
        check_eq("reset.wr_data", 32'(wr_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("idle", 8'h00, 3'd0, 1'b0);
        end
        check_eq("idle.busy", 32'(busy), 32'h0);

        // Two requesters alternate every MAX_HOLD cycles
        req = 8'h24;
        #1 check_eq("rr.busy", 32'(busy), 32'h1);
        for (int i = 0; i < 12; i++) begin
            step();
            eg = ((i / 4) % 2 == 0) ? 8'h04 : 8'h20;
            es = ((i / 4) % 2 == 0) ? 3'd2 : 3'd5;
            chk_out("rr", eg, es, 1'b1);
            check_eq("rr.wr_data", 32'(wr_data), 32'(16'h1111 * es));
        end
        req = 8'h00;
        step();
        chk_out("rr_drop", 8'h00, 3'd2, 1'b0);

        // ptr wraps 7 -> 0 on handover
        req = 8'h80;
        step();
        chk_out("wrap0", 8'h80, 3'd7, 1'b1);
        req = 8'h81;
        for (int j = 0; j < 4; j++) begin
            step();
            if (prio || j == 3) chk_out("wrap1", 8'h01, 3'd0, 1'b1);
            else chk_out("wrap1", 8'h80, 3'd7, 1'b1);
        end
        req = 8'h00;
        step();
        chk_out("wrap_drop", 8'h00, 3'd0, 1'b0);

        // Lone requester keeps the grant past MAX_HOLD, data tracks with one-cycle lag
        req = 8'h08;
        for (int i = 0; i < 10; i++) begin
            req_data[3*DW +: DW] = 16'(16'hA000 + i);
            step();
            chk_out("solo", 8'h08, 3'd3, 1'b1);
            check_eq("solo.wr_data", 32'(wr_data), 32'(16'hA000 + i));
        end
        req = 8'h00;
        step();
        chk_out("solo_drop", 8'h00, 3'd3, 1'b0);

        // Asynchronous reset while granted
        req = 8'h10;
        step();
        chk_out("pre_rst", 8'h10, 3'd4, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 8'h00, 3'd0, 1'b0);
        check_eq("async_rst.wr_data", 32'(wr_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'hFF;
        step();
        chk_out("post_rst", 8'h01, 3'd0, 1'b1);
        check_eq("post_rst.wr_data", 32'(wr_data), 32'h0);

        // Requester 0 rising while requester 6 owns the path
        req = 8'h00;
        step();
        req = 8'h40;
        step();
        chk_out("prio_pre", 8'h40, 3'd6, 1'b1);
        req = 8'h41;
        step();
        if (prio) chk_out("prio", 8'h01, 3'd0, 1'b1);
        else chk_out("prio", 8'h40, 3'd6, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
